// File: rtl/lock_controller.sv
// lock_controller: collects code presses, checks the comparator result, runs unlock window and lockout
module lock_controller #(
    parameter int N              = 4,
    parameter int MAX_TRIES      = 3,
    parameter int UNLOCK_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_valid,
    input  logic         btn_bit,
    input  logic         clear,
    input  logic         match,
    output logic [N-1:0] entered,
    output logic         unlocked,
    output logic         locked_out,
    output logic         fail_pulse,
    output logic [3:0]   tries_left,
    output logic         busy
);
    localparam int CW   = $clog2(N + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, CHECK, OPEN, LOCKOUT} state_t;

    state_t        state, state_n;
    logic [N-1:0]  entered_n;
    logic [CW-1:0] count, count_n;
    logic [3:0]    fails, fails_n;
    logic [TW-1:0] timer, timer_n;
    logic          unlocked_n, locked_out_n, fail_pulse_n;

    assign tries_left = 4'(MAX_TRIES) - fails;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entered    <= '0;
            count      <= '0;
            fails      <= '0;
            timer      <= '0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
            fail_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            entered    <= entered_n;
            count      <= count_n;
            fails      <= fails_n;
            timer      <= timer_n;
            unlocked   <= unlocked_n;
            locked_out <= locked_out_n;
            fail_pulse <= fail_pulse_n;
            busy       <= (state_n != IDLE);
        end
    end

    // next-state and next-value logic; presses are only accepted while idle/entering
    always_comb begin
        state_n      = state;
        entered_n    = entered;
        count_n      = count;
        fails_n      = fails;
        timer_n      = timer;
        unlocked_n   = unlocked;
        locked_out_n = locked_out;
        fail_pulse_n = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    entered_n = '0;
                    count_n   = '0;
                end else if (btn_valid) begin
                    entered_n = {entered[N-2:0], btn_bit};
                    if (count == CW'(N - 1)) begin
                        count_n = '0;
                        state_n = CHECK;
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
            end
            CHECK: begin
                entered_n = '0;
                if (match) begin
                    state_n    = OPEN;
                    timer_n    = TW'(UNLOCK_CYCLES);
                    unlocked_n = 1'b1;
                    fails_n    = '0;
                end else begin
                    fail_pulse_n = 1'b1;
                    fails_n      = (fails >= 4'(MAX_TRIES)) ? fails : fails + 4'd1;
                    if (fails_n == 4'(MAX_TRIES)) begin
                        state_n      = LOCKOUT;
                        timer_n      = TW'(LOCKOUT_CYCLES);
                        locked_out_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            OPEN: begin
                if (clear || timer <= TW'(1)) begin
                    state_n    = IDLE;
                    unlocked_n = 1'b0;
                    timer_n    = '0;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            LOCKOUT: begin
                if (timer <= TW'(1)) begin
                    state_n      = IDLE;
                    locked_out_n = 1'b0;
                    fails_n      = '0;
                    timer_n      = '0;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lock_controller.sv
// tb_lock_controller: scoreboard bench for lock_controller with a 1110 comparator
module tb_lock_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_valid = 1'b0;
    logic       btn_bit = 1'b0;
    logic       clear = 1'b0;
    logic       match;
    logic [3:0] entered;
    logic       unlocked, locked_out, fail_pulse, busy;
    logic [3:0] tries_left;

    typedef struct {
        string       tag;
        logic [11:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    lock_controller dut (
        .clk(clk), .rst(rst), .btn_valid(btn_valid), .btn_bit(btn_bit), .clear(clear),
        .match(match), .entered(entered), .unlocked(unlocked), .locked_out(locked_out),
        .fail_pulse(fail_pulse), .tries_left(tries_left), .busy(busy)
    );

    assign match = (entered == 4'b1110);

    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        return {entered, unlocked, locked_out, fail_pulse, busy, tries_left};
    endfunction

    function automatic logic [11:0] e(input logic [3:0] ent, input logic u, input logic lo,
                                      input logic fp, input logic bz, input logic [3:0] tl);
        return {ent, u, lo, fp, bz, tl};
    endfunction

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (entered,unl,lock,fail,busy,tries)", tag, got, want);
        end
    endtask

    // compare the DUT against the oldest pending expectation once per cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk(x.tag, obs(), x.v);
        end
    end

    task automatic step(input logic v, input logic b, input logic c, input string tag, input logic [11:0] x);
        @(negedge clk);
        #1;
        btn_valid = v;
        btn_bit   = b;
        clear     = c;
        q.push_back('{tag, x});
    endtask

    task automatic enter(input logic [3:0] code, input logic [3:0] tl);
        logic [3:0] ent;
        ent = '0;
        for (int i = 0; i < 4; i++) begin
            ent = {ent[2:0], code[3-i]};
            step(1'b1, code[3-i], 1'b0, "press", e(ent, 1'b0, 1'b0, 1'b0, i == 3, tl));
        end
    endtask

    task automatic open_win();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, "open", e(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3));
        step(1'b0, 1'b0, 1'b0, "open_end", e(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3));
    endtask

    task automatic fail_try(input logic [3:0] tl);
        enter(4'b1010, tl);
        step(1'b0, 1'b0, 1'b0, "fail", e(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, tl - 4'd1));
        step(1'b0, 1'b0, 1'b0, "fail_idle", e(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, tl - 4'd1));
    endtask

    task automatic lockout();
        enter(4'b1010, 4'd1);
        step(1'b0, 1'b0, 1'b0, "lock", e(4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0));
        for (int i = 0; i < 15; i++)
            step(1'b1, i[0], i == 5, "lock_hold", e(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0));
        step(1'b0, 1'b0, 1'b0, "lock_end", e(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3));
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk(tag, obs(), e(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3));
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset", obs(), e(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3));
        rst = 1'b0;
        enter(4'b1110, 4'd3);
        open_win();
        fail_try(4'd3);
        fail_try(4'd2);
        lockout();
        enter(4'b1110, 4'd3);
        open_win();
        fail_try(4'd3);
        fail_try(4'd2);
        enter(4'b1110, 4'd1);
        open_win();
        fail_try(4'd3);
        step(1'b1, 1'b1, 1'b0, "pre_clr", e(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2));
        step(1'b1, 1'b1, 1'b0, "pre_clr", e(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2));
        step(1'b1, 1'b1, 1'b1, "clr_press", e(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2));
        enter(4'b1110, 4'd2);
        open_win();
        enter(4'b1110, 4'd3);
        step(1'b0, 1'b0, 1'b0, "open", e(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3));
        step(1'b0, 1'b0, 1'b0, "open", e(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3));
        step(1'b0, 1'b0, 1'b1, "clr_open", e(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3));
        step(1'b0, 1'b0, 1'b0, "idle", e(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3));
        enter(4'b1110, 4'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "open", e(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3));
        async_reset("arst_open");
        fail_try(4'd3);
        fail_try(4'd2);
        enter(4'b1010, 4'd1);
        step(1'b0, 1'b0, 1'b0, "lock", e(4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0));
        step(1'b0, 1'b0, 1'b0, "lock_hold", e(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0));
        step(1'b0, 1'b0, 1'b0, "lock_hold", e(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0));
        async_reset("arst_lock");
        enter(4'b1110, 4'd3);
        open_win();
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        chk("drain", 12'(q.size()), 12'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
